// File: rtl/phase_update_sequencer_pkg.sv
// Shared definitions for the phase update sequencer: state encoding,
// panel count and the panel-index to top/left select mapping.
package phase_update_sequencer_pkg;

  localparam int NUM_PANELS  = 4;
  localparam int PANEL_IDX_W = 2;
  localparam logic [PANEL_IDX_W-1:0] LAST_PANEL = PANEL_IDX_W'(NUM_PANELS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    COMMIT,
    SWAP_PEND,
    SWAP
  } seqState_t;

  // Panels 0..3 map to (top,left) = (0,1), (0,0), (1,1), (1,0).
  function automatic logic panelTop(input logic [PANEL_IDX_W-1:0] p);
    return p[1];
  endfunction

  function automatic logic panelLeft(input logic [PANEL_IDX_W-1:0] p);
    return ~p[0];
  endfunction

  function automatic logic [NUM_PANELS-1:0] panelOneHot(input logic [PANEL_IDX_W-1:0] p);
    return NUM_PANELS'(1) << p;
  endfunction

endpackage

// File: rtl/phase_update_sequencer.sv
// Phase update sequencer: accepts a target position, runs the phase
// calculator once per panel, commits each panel's result into its shadow
// registers and swaps the frame in on the next PWM period boundary.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | ready for a new position (pos_ready=1)
// LAUNCH    | one-cycle calc_start for the current panel, timer cleared
// WAIT      | waiting for a calc_done rising edge, timer running
// COMMIT    | one-cycle panel_commit pulse for the current panel
// SWAP_PEND | all panels committed, waiting for cycle_start
// SWAP      | one-cycle frame_swap / calc_cycle_start, frame_cnt bumped
module phase_update_sequencer
  import phase_update_sequencer_pkg::*;
#(
  parameter int POS_BIT_SIZE   = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic [POS_BIT_SIZE-1:0] pos_x,
  input  logic [POS_BIT_SIZE-1:0] pos_y,
  input  logic [POS_BIT_SIZE-1:0] pos_z,
  input  logic                    pos_valid,
  output logic                    pos_ready,
  output logic [POS_BIT_SIZE-1:0] calc_x,
  output logic [POS_BIT_SIZE-1:0] calc_y,
  output logic [POS_BIT_SIZE-1:0] calc_z,
  output logic                    calc_start,
  output logic                    calc_top,
  output logic                    calc_left,
  input  logic                    calc_done,
  output logic                    calc_cycle_start,
  input  logic                    cycle_start,
  output logic [NUM_PANELS-1:0]   panel_commit,
  output logic                    frame_swap,
  output logic [15:0]             frame_cnt,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  seqState_t              state;
  logic [PANEL_IDX_W-1:0] panelIdx;
  logic [CNT_W-1:0]       waitCnt;
  logic [CNT_W-1:0]       waitCntInc;
  logic                   doneQ;
  logic                   doneRise;
  logic                   timeoutEvt;

  // Only a fresh 0->1 transition counts, so a done level left high by the
  // previous panel cannot complete the next one.
  assign doneRise   = calc_done & ~doneQ;
  assign waitCntInc = waitCnt + CNT_W'(1);
  // The timeout fires on the edge at which the counter would reach its last
  // value; a done edge in that same cycle still wins.
  assign timeoutEvt = (state == WAIT) && !doneRise && (waitCntInc == CNT_LAST);

  // The panel selects follow the panel index, which only moves between runs.
  assign calc_top  = panelTop(panelIdx);
  assign calc_left = panelLeft(panelIdx);

  // Delay calc_done by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) doneQ <= 1'b0;
    else         doneQ <= calc_done;
  end

  // Sticky timeout flag; setting wins over a coincident clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)         timeout_err <= 1'b0;
    else if (timeoutEvt) timeout_err <= 1'b1;
    else if (err_clr)    timeout_err <= 1'b0;
  end

  // Sequencer FSM with all handshake and pulse outputs registered.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state            <= IDLE;
      panelIdx         <= '0;
      waitCnt          <= '0;
      calc_x           <= '0;
      calc_y           <= '0;
      calc_z           <= '0;
      calc_start       <= 1'b0;
      panel_commit     <= '0;
      frame_swap       <= 1'b0;
      calc_cycle_start <= 1'b0;
      frame_cnt        <= '0;
      pos_ready        <= 1'b0;
      busy             <= 1'b0;
    end else begin
      calc_start       <= 1'b0;
      panel_commit     <= '0;
      frame_swap       <= 1'b0;
      calc_cycle_start <= 1'b0;
      unique case (state)
        IDLE: begin
          pos_ready <= 1'b1;
          busy      <= 1'b0;
          if (pos_valid && pos_ready) begin
            calc_x     <= pos_x;
            calc_y     <= pos_y;
            calc_z     <= pos_z;
            panelIdx   <= '0;
            calc_start <= 1'b1;
            pos_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (doneRise) begin
            panel_commit <= panelOneHot(panelIdx);
            state        <= COMMIT;
          end else if (timeoutEvt) begin
            pos_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            waitCnt <= waitCntInc;
          end
        end
        COMMIT: begin
          if (panelIdx != LAST_PANEL) begin
            panelIdx   <= panelIdx + PANEL_IDX_W'(1);
            calc_start <= 1'b1;
            state      <= LAUNCH;
          end else begin
            state <= SWAP_PEND;
          end
        end
        SWAP_PEND: begin
          if (cycle_start) begin
            frame_swap       <= 1'b1;
            calc_cycle_start <= 1'b1;
            frame_cnt        <= frame_cnt + 16'd1;
            state            <= SWAP;
          end
        end
        SWAP: begin
          pos_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          pos_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
